// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler sharing one valid/ready stream among NCH FIFOs in the rclk domain.
// Optional handshake counter port stat_words is enabled with `define FIFO_RD_ARB_STAT_EN.
module fifo_rd_arbiter #(
    parameter int NCH       = 4,
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 8,
    localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 clr,
    input  logic [NCH-1:0]       rempty,
    input  logic [NCH-1:0]       rempty_almost,
    output logic [NCH-1:0]       rd_req_n,
    input  logic [NCH*DSIZE-1:0] rdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DSIZE-1:0]     m_data,
    output logic [CW-1:0]        m_chan,
    output logic                 m_last,
    output logic                 busy
`ifdef FIFO_RD_ARB_STAT_EN
    ,
    output logic [31:0]          stat_words
`endif
);

    localparam int unsigned NCH_U    = NCH;
    localparam logic [7:0]  BURST_L8 = 8'(BURST_LEN);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCH_U) s = s - NCH_U;
        return CW'(s);
    endfunction

    state_t          state_reg, state_next;
    logic [CW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]   grant_reg, grant_next;
    logic [7:0]      limit_reg, limit_next;
    logic [7:0]      burst_cnt_reg, burst_cnt_next;

    logic            inflight_reg;
    logic            inflight_last_reg;
    logic [CW-1:0]   inflight_chan_reg;

    logic [DSIZE-1:0] buf_data [2];
    logic [CW-1:0]    buf_chan [2];
    logic             buf_last [2];
    logic             buf_wr_ptr_reg;
    logic             buf_rd_ptr_reg;
    logic [1:0]       buf_cnt_reg;

    logic [CW-1:0]    cand_ch  [NCH];
    logic [NCH-1:0]   cand_hit;
    logic [DSIZE-1:0] rdata_ch [NCH];

    logic            hit;
    logic [CW-1:0]   hit_ch;
    logic            pop;
    logic            push;
    logic            push_last;
    logic [2:0]      occupancy;
    logic            credit_ok;
    logic            g_empty;
    logic            issue;
    logic [7:0]      cnt_inc;
    logic            burst_done;
    logic            end_empty;

    // Candidate order for the round-robin search: offset gi from rr_ptr.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign cand_ch[gi]  = wrap_add(rr_ptr_reg, gi);
        assign cand_hit[gi] = ~rempty[cand_ch[gi]];
        assign rdata_ch[gi] = rdata[gi*DSIZE +: DSIZE];
        assign rd_req_n[gi] = ~(issue && (grant_reg == CW'(gi)));
    end

    always_comb begin
        hit    = 1'b0;
        hit_ch = rr_ptr_reg;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                hit    = 1'b1;
                hit_ch = cand_ch[i];
            end
        end
    end

    // Buffer slots already promised (stored + in flight) minus the one leaving this cycle.
    assign pop        = m_valid & m_ready;
    assign push       = inflight_reg;
    assign occupancy  = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg};
    assign credit_ok  = occupancy < (3'd2 + {2'b00, pop});
    assign g_empty    = rempty[grant_reg];
    assign issue      = (state_reg == GRANT) && !g_empty && credit_ok && !clr;
    assign cnt_inc    = burst_cnt_reg + 8'd1;
    assign burst_done = issue && (cnt_inc == limit_reg);
    assign end_empty  = (state_reg == GRANT) && g_empty && !issue && !clr;
    assign push_last  = inflight_last_reg | (end_empty & inflight_reg);

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        limit_next     = limit_reg;
        burst_cnt_next = burst_cnt_reg;
        if (clr) begin
            state_next     = IDLE;
            burst_cnt_next = 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        grant_next     = hit_ch;
                        limit_next     = rempty_almost[hit_ch] ? 8'd1 : BURST_L8;
                        burst_cnt_next = 8'd0;
                        state_next     = GRANT;
                    end
                end
                GRANT: begin
                    if (issue) burst_cnt_next = cnt_inc;
                    if (burst_done || end_empty) begin
                        state_next  = IDLE;
                        rr_ptr_next = wrap_add(grant_reg, 1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            limit_reg     <= 8'd0;
            burst_cnt_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            limit_reg     <= limit_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // In-flight tracking and the 2-entry skid buffer absorbing the FIFO read latency.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            inflight_chan_reg <= '0;
            buf_wr_ptr_reg    <= 1'b0;
            buf_rd_ptr_reg    <= 1'b0;
            buf_cnt_reg       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_chan[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else if (clr) begin
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            buf_wr_ptr_reg    <= 1'b0;
            buf_rd_ptr_reg    <= 1'b0;
            buf_cnt_reg       <= 2'd0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= burst_done;
            inflight_chan_reg <= grant_reg;
            if (push) begin
                buf_data[buf_wr_ptr_reg] <= rdata_ch[inflight_chan_reg];
                buf_chan[buf_wr_ptr_reg] <= inflight_chan_reg;
                buf_last[buf_wr_ptr_reg] <= push_last;
                buf_wr_ptr_reg           <= ~buf_wr_ptr_reg;
            end else if (end_empty && buf_cnt_reg != 2'd0) begin
                // Last read already landed: retro-tag the newest stored word.
                buf_last[~buf_wr_ptr_reg] <= 1'b1;
            end
            if (pop) buf_rd_ptr_reg <= ~buf_rd_ptr_reg;
            buf_cnt_reg <= buf_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_valid = (buf_cnt_reg != 2'd0);
    assign m_data  = buf_data[buf_rd_ptr_reg];
    assign m_chan  = buf_chan[buf_rd_ptr_reg];
    assign m_last  = buf_last[buf_rd_ptr_reg];
    assign busy    = (state_reg == GRANT) | inflight_reg | (buf_cnt_reg != 2'd0);

`ifdef FIFO_RD_ARB_STAT_EN
    logic [31:0] stat_words_reg;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stat_words_reg <= 32'd0;
        end else if (clr) begin
            stat_words_reg <= 32'd0;
        end else if (pop) begin
            stat_words_reg <= stat_words_reg + 32'd1;
        end
    end

    assign stat_words = stat_words_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: behavioural FIFOs feed the arbiter, output words are scoreboarded.
module tb_fifo_rd_arbiter;

    logic        clk;
    logic        rrst_n;
    logic        clr;
    logic [3:0]  rempty;
    logic [3:0]  rempty_almost;
    logic [3:0]  rd_req_n;
    logic [31:0] rdata;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_chan;
    logic        m_last;
    logic        busy;
`ifdef FIFO_RD_ARB_STAT_EN
    logic [31:0] stat_words;
`endif

    int checks = 0;
    int errors = 0;

    int         pushed [4];
    int         popped [4];
    logic [7:0] rd_m   [4];

    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    fifo_rd_arbiter #(.NCH(4), .DSIZE(8), .BURST_LEN(8)) dut (
        .rclk          (clk),
        .rrst_n        (rrst_n),
        .clr           (clr),
        .rempty        (rempty),
        .rempty_almost (rempty_almost),
        .rd_req_n      (rd_req_n),
        .rdata         (rdata),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_chan        (m_chan),
        .m_last        (m_last),
        .busy          (busy)
`ifdef FIFO_RD_ARB_STAT_EN
        ,
        .stat_words    (stat_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word k of channel c carries data c*16 + k mod 16.
    function automatic logic [15:0] mkw(input int ch, input int seq, input bit last);
        logic [15:0] r;
        r = {3'b000, last, 4'(ch), 8'(ch * 16 + seq % 16)};
        return r;
    endfunction

    // Behavioural FIFOs: registered read data, empty flag updates the cycle after a read.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
        assign rempty[gi]             = (pushed[gi] == popped[gi]);
        assign rdata[gi*8 +: 8]       = rd_m[gi];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rd_req_n[k]) begin
                rd_m[k]   <= 8'(k * 16 + popped[k] % 16);
                popped[k] <= popped[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rrst_n) begin
            check("rdreq_legal",
                  (($countones(~rd_req_n) <= 1) && ((~rd_req_n & rempty) == 4'd0)), 1);
            if (m_valid && m_ready) begin
                got_q.push_back({3'b000, m_last, 2'b00, m_chan, m_data});
                $display("word ch=%0d data=%02h last=%0d", m_chan, m_data, m_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int n);
        pushed[ch] = pushed[ch] + n;
    endtask

    task automatic collect(input string tag);
        int cyc;
        int n;
        cyc = 0;
        n = exp_q.size();
        while (got_q.size() < n && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    endtask

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rrst_n        = 1'b0;
        clr           = 1'b0;
        m_ready       = 1'b0;
        rempty_almost = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_rd_req_n", rd_req_n, 4'hF);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_chan", m_chan, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
`ifdef FIFO_RD_ARB_STAT_EN
        check("rst_stat", stat_words, 0);
`endif
        tick();
        rrst_n = 1'b1;
        repeat (2) tick();

        // ch2 with 20 words: bursts of 8, 8, then 4 ending on empty; latency of 3 edges.
        start_test();
        m_ready = 1'b1;
        for (int j = 0; j < 20; j++) exp_q.push_back(mkw(2, j, (j == 7 || j == 15 || j == 19)));
        load(2, 20);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_e0", m_valid, 0);
        check("lat_rdreq_e0", rd_req_n, 4'b1011);
        check("lat_busy_e0", busy, 1);
        @(negedge clk);
        check("lat_valid_e1", m_valid, 0);
        check("lat_rdreq_e1", rd_req_n, 4'b1011);
        @(negedge clk);
        check("lat_valid_e2", m_valid, 1);
        check("lat_data_e2", m_data, 8'h20);
        check("lat_chan_e2", m_chan, 2);
        collect("burst_ch2");
        check("idle_rdreq", rd_req_n, 4'hF);
        check("idle_busy", busy, 0);
        check("ch2_reads", popped[2], 20);

        // Single word on ch0 moves rr_ptr to 1.
        start_test();
        exp_q.push_back(mkw(0, 0, 1));
        load(0, 1);
        collect("ch0_single");

        // ch0 and ch3 pending with rr_ptr=1: ch3 first, then ch0.
        start_test();
        exp_q.push_back(mkw(3, 0, 0));
        exp_q.push_back(mkw(3, 1, 1));
        exp_q.push_back(mkw(0, 1, 0));
        exp_q.push_back(mkw(0, 2, 1));
        load(0, 2);
        load(3, 2);
        collect("rr_order");

        // Almost-empty ch1: three one-word grants, every word last.
        start_test();
        rempty_almost = 4'b0010;
        for (int j = 0; j < 3; j++) exp_q.push_back(mkw(1, j, 1));
        load(1, 3);
        collect("almost_ch1");
        rempty_almost = 4'b0000;

        // Backpressure from the start: two reads fill the buffer, then issue stalls.
        start_test();
        m_ready = 1'b0;
        for (int j = 2; j < 10; j++) exp_q.push_back(mkw(3, j, (j == 9)));
        load(3, 8);
        repeat (3) @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_rdreq", rd_req_n, 4'hF);
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, 8'h32);
            check("stall_chan", m_chan, 3);
        end
        check("stall_reads", popped[3], 4);
        tick();
        m_ready = 1'b1;
        collect("stall_resume");

        // ch0 with 5 words and BURST_LEN 8: grant ends on empty, 5th word last.
        start_test();
        for (int j = 3; j < 8; j++) exp_q.push_back(mkw(0, j, (j == 7)));
        load(0, 5);
        collect("empty_end");
`ifdef FIFO_RD_ARB_STAT_EN
        check("stat_total", stat_words, 41);
`endif

        // clr with a full buffer, then clr during a grant that would issue a read.
        start_test();
        tick();
        m_ready = 1'b0;
        load(1, 4);
        repeat (4) tick();
        check("clr_pre_valid", m_valid, 1);
        check("clr_pre_data", m_data, 8'h13);
        check("clr_pre_reads", popped[1], 5);
        clr = 1'b1;
        @(negedge clk);
        check("clr_rdreq_a", rd_req_n, 4'hF);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_valid", m_valid, 0);
        check("clr_busy", busy, 0);
`ifdef FIFO_RD_ARB_STAT_EN
        check("clr_stat", stat_words, 0);
`endif
        tick();
        clr = 1'b1;
        @(negedge clk);
        check("clr_rdreq_b", rd_req_n, 4'hF);
        tick();
        clr = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("clr_suppressed", popped[1], 5);
        exp_q.push_back(mkw(1, 5, 0));
        exp_q.push_back(mkw(1, 6, 1));
        collect("post_clr");
        check("post_clr_reads", popped[1], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
